adc_conv_ctrl: RTL

- Synchronous controller directly upstream and downstream of the asynchronous 10-bit SAR ADC.
- On a trigger it drives the ADC `sample` line, releases it to start conversion, and synchronizes the ADC's asynchronous `done`.
- It then captures `dout` and presents a timestamped word to the digital readout over a valid/ready handshake.
- A conversion that never completes is detected by a timeout and reported as a flagged word.

---
 rtl/adc_conv_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/adc_conv_ctrl.sv
// Sample/convert/readout sequencer for an asynchronous SAR ADC, with a conversion timeout.
// Optional build macro ADC_THRESH_EN: conversions whose code is below `threshold` are discarded.
module adc_conv_ctrl #(
  parameter int ADCBITS    = 10,
  parameter int TSBITS     = 16,
  parameter int TIMEOUT    = 64,
  parameter int MIN_SAMPLE = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      trigger,
  input  logic [7:0]                sample_cycles,
  input  logic                      adc_done,
  input  logic [ADCBITS-1:0]        adc_dout,
  output logic                      sample,
  output logic                      busy,
  output logic [TSBITS+ADCBITS:0]   data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
`ifdef ADC_THRESH_EN
  input  logic [ADCBITS-1:0]        threshold,
  output logic [7:0]                discarded,
`endif
  output logic [7:0]                dropped
);

  // state     | meaning
  // IDLE      | waiting for a trigger rising edge
  // SAMPLE    | sample high, scnt counting down the track time
  // WAIT_DONE | conversion running, tcnt counting down to timeout
  // OUTPUT    | word presented, held until data_ready

  typedef enum logic [1:0] {IDLE, SAMPLE, WAIT_DONE, OUTPUT} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MIN_S  = 8'(MIN_SAMPLE);

  state_t              state;
  logic [7:0]          scnt;
  logic [TW-1:0]       tcnt;
  logic [TSBITS-1:0]   timestamp;
  logic [TSBITS-1:0]   ts_cap;
  logic                trigger_d;
  logic                done_meta, done_s, done_s_d;
  logic                trig_rise, done_rise;
  logic [7:0]          s_load;

  assign trig_rise = trigger & ~trigger_d;
  assign done_rise = done_s & ~done_s_d;
  assign s_load    = (sample_cycles < MIN_S) ? MIN_S : sample_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timestamp <= '0;
      trigger_d <= 1'b0;
      done_meta <= 1'b0;
      done_s    <= 1'b0;
      done_s_d  <= 1'b0;
    end else begin
      timestamp <= timestamp + TSBITS'(1);
      trigger_d <= trigger;
      done_meta <= adc_done;
      done_s    <= done_meta;
      done_s_d  <= done_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sample     <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      dropped    <= '0;
      scnt       <= '0;
      tcnt       <= '0;
      ts_cap     <= '0;
`ifdef ADC_THRESH_EN
      discarded  <= '0;
`endif
    end else begin
      // The acceptance cycle is still OUTPUT, so a trigger there counts as dropped.
      if (trig_rise && state != IDLE && dropped != 8'hFF)
        dropped <= dropped + 8'd1;

      unique case (state)
        IDLE: begin
          if (trig_rise) begin
            ts_cap <= timestamp;
            scnt   <= s_load;
            sample <= 1'b1;
            busy   <= 1'b1;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (scnt == 8'd1) begin
            sample <= 1'b0;
            tcnt   <= T_LOAD;
            state  <= WAIT_DONE;
          end else begin
            scnt <= scnt - 8'd1;
          end
        end
        WAIT_DONE: begin
          // done_rise is checked first so it wins over a simultaneous timeout.
          if (done_rise) begin
`ifdef ADC_THRESH_EN
            if (adc_dout < threshold) begin
              busy  <= 1'b0;
              state <= IDLE;
              if (discarded != 8'hFF)
                discarded <= discarded + 8'd1;
            end else begin
              data_out   <= {1'b0, ts_cap, adc_dout};
              data_valid <= 1'b1;
              state      <= OUTPUT;
            end
`else
            data_out   <= {1'b0, ts_cap, adc_dout};
            data_valid <= 1'b1;
            state      <= OUTPUT;
`endif
          end else if (tcnt == '0) begin
            data_out   <= {1'b1, ts_cap, {ADCBITS{1'b0}}};
            data_valid <= 1'b1;
            state      <= OUTPUT;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        OUTPUT: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
